// File: rtl/load_store_pkg.sv
// Shared types, funct3 encodings and access-size helpers for the load/store unit.
package load_store_pkg;

  localparam int unsigned LS_DW = 32;

  // Legacy state encodings; the enum below is bound to them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Undefined encodings fall back to word; for stores bit 2 never changes the size.
  function automatic size_e size_of(input logic [2:0] f3);
    size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Byte lane of the access, with sub-size alignment bits forced to zero.
  function automatic logic [1:0] lane_of(input size_e sz, input logic [1:0] off);
    logic [1:0] lane;
    case (sz)
      SZ_B:    lane = off;
      SZ_H:    lane = {off[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    return ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 16
) ();
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      rsp_valid;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      busy;
  logic                      mem_en;
  logic                      mem_we;
  logic [3:0]                mem_be;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  // CPU plus data memory around the unit.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables and store shifting, load lane select and extension.
module load_store_align
  import load_store_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       off_i,
  input  logic [LS_DW-1:0] wdata_i,
  input  logic [LS_DW-1:0] rdata_i,
  output logic [3:0]       be_o,
  output logic [LS_DW-1:0] wdata_o,
  output logic [LS_DW-1:0] rdata_o
);

  size_e            size;
  logic [1:0]       lane;
  logic [LS_DW-1:0] rshift;

  // Decode size/lane once, then shape enables, store data and extended load data.
  always_comb begin
    size    = size_of(funct3_i);
    lane    = lane_of(size, off_i);
    wdata_o = wdata_i << {lane, 3'b000};
    rshift  = rdata_i >> {lane, 3'b000};
    be_o    = 4'b1111;
    rdata_o = rshift;
    case (size)
      SZ_B: begin
        be_o    = 4'b0001 << lane;
        rdata_o = funct3_i[2] ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      end
      SZ_H: begin
        be_o    = 4'b0011 << lane;
        rdata_o = funct3_i[2] ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        rdata_o = rshift;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: IDLE -> ISSUE -> (WAIT) -> DONE, one request at a time.
// Optional feature macro: LOAD_STORE_MISALIGN_TRAP_EN (misaligned H/W requests skip
// memory and complete next cycle with rsp_err set).
module load_store_unit
  import load_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [2:0]                funct3_q, funct3_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  logic                      err_q, err_d;
`endif

  logic [3:0]            al_be;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_rdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

  load_store_align u_align (
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (bus.mem_rdata),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  // Next-state and request/response register updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr[MEM_ADDR_WIDTH+1:0];
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          wdata_d  = bus.req_wdata;
          state_d  = S_ISSUE;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
          if (misaligned(size_of(bus.req_funct3), bus.req_addr[1:0])) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          rdata_d = '0;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
          err_d   = 1'b0;
`endif
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rdata_d = al_rdata;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
        err_d   = 1'b0;
`endif
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_rdata = rdata_q;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  // Memory strobes are only driven during ISSUE; everything reads zero otherwise.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == S_ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_be    = al_be;
      bus.mem_addr  = addr_q[MEM_ADDR_WIDTH+1:2];
      bus.mem_wdata = al_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_load_store_unit;

`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(16)) bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment memory: synchronous read, byte-enabled write, noise when not read.
  logic [31:0] env_mem [64];
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= env_mem[bus.mem_addr[5:0]];
    else                           bus.mem_rdata <= $urandom;
    if (bus.mem_en && bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) env_mem[bus.mem_addr[5:0]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_start, m_lat, m_sz, m_eoff, m_idx;
  bit          m_we, m_trap, m_err;
  logic [31:0] m_rdata, m_wdata, m_wd_raw;
  logic [3:0]  m_be;
  logic [15:0] m_maddr;
  logic [31:0] last_rdata = '0;
  bit          last_err = 1'b0;
  bit          after_rst = 1'b0;
  bit          chk_en = 1'b0;

  function automatic int size_bytes(input logic [2:0] f3, input logic we);
    logic [2:0] f;
    f = we ? (f3 & 3'b011) : f3;
    if (f == 3'b000 || f == 3'b100) return 1;
    if (f == 3'b001 || f == 3'b101) return 2;
    return 4;
  endfunction

  // Model: accept, write at the issue cycle, retire at the done cycle, reset drops all.
  always @(posedge clk) begin
    bit          was_idle;
    int          k;
    logic [31:0] w, v, mask;
    logic [1:0]  off;
    was_idle = !m_active;
    if (m_active) begin
      k = cyc - m_start;
      if (k == 1 && m_we && !m_trap)
        for (int b = 0; b < m_sz; b++) ref_mem[m_idx][8*(m_eoff+b) +: 8] = m_wd_raw[8*b +: 8];
      if (k == m_lat) begin
        m_active   = 1'b0;
        last_rdata = m_rdata;
        last_err   = m_err;
      end
    end
    after_rst = rst;
    if (rst) begin
      m_active   = 1'b0;
      last_rdata = '0;
      last_err   = 1'b0;
    end else if (was_idle && bus.req_valid) begin
      off      = bus.req_addr[1:0];
      m_sz     = size_bytes(bus.req_funct3, bus.req_we);
      m_eoff   = int'(off) - (int'(off) % m_sz);
      m_we     = bus.req_we;
      m_idx    = int'(bus.req_addr[7:2]);
      m_maddr  = bus.req_addr[17:2];
      m_wd_raw = bus.req_wdata;
      m_be     = 4'(((1 << m_sz) - 1) << m_eoff);
      m_wdata  = bus.req_wdata << (8 * m_eoff);
      m_trap   = TRAP && ((m_sz == 2 && off[0]) || (m_sz == 4 && off != 2'b00));
      m_active = 1'b1;
      m_start  = cyc;
      if (m_trap) begin
        m_lat = 1; m_rdata = '0; m_err = 1'b1;
      end else if (m_we) begin
        m_lat = 2; m_rdata = '0; m_err = 1'b0;
      end else begin
        m_lat = 3; m_err = 1'b0;
        w = ref_mem[m_idx];
        v = w >> (8 * m_eoff);
        if (m_sz < 4) begin
          mask = (32'h1 << (8 * m_sz)) - 32'h1;
          v = v & mask;
          if (!(bus.req_funct3 == 3'b100 || bus.req_funct3 == 3'b101) && v[8*m_sz-1])
            v = v | ~mask;
        end
        m_rdata = v;
      end
    end
    cyc++;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    int          k;
    bit          issue, done;
    logic [31:0] wmask;
    if (chk_en) begin
      k     = m_active ? (cyc - m_start) : 0;
      issue = m_active && k == 1 && !m_trap;
      done  = m_active && k == m_lat;
      wmask = '0;
      for (int b = 0; b < 4; b++) if (m_be[b]) wmask[8*b +: 8] = 8'hFF;
      check("req_ready", bus.req_ready, !m_active);
      check("busy", bus.busy, m_active);
      check("mem_en", bus.mem_en, issue);
      check("mem_we", bus.mem_we, issue && m_we);
      check("mem_be", bus.mem_be, issue ? m_be : 4'b0);
      check("rsp_valid", bus.rsp_valid, done);
      check("rsp_rdata", bus.rsp_rdata, done ? m_rdata : last_rdata);
      check("rsp_err", bus.rsp_err, done ? m_err : last_err);
      if (issue) begin
        check("mem_addr", bus.mem_addr, m_maddr);
        check("mem_wdata", bus.mem_wdata & wmask, m_wdata & wmask);
      end
      if (after_rst) begin
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst mem_wdata", bus.mem_wdata, 0);
      end
    end
  end

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err, output bit saw_en, output logic [15:0] ia,
                         output logic [3:0] ibe, output logic [31:0] iwd);
    int g;
    lat = -1; rdata = '0; err = 1'b0; saw_en = 1'b0; ia = '0; ibe = '0; iwd = '0;
    g = 0;
    @(negedge clk);
    while (!bus.req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        saw_en = 1'b1; ia = bus.mem_addr; ibe = bus.mem_be; iwd = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        lat = n; rdata = bus.rsp_rdata; err = bus.rsp_err;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, d1, d2;
    logic [31:0] rd, iwd;
    logic        er, r2, r3;
    bit          en, dropped;
    logic [15:0] ia;
    logic [3:0]  ibe;

    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b1;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;

    // Preload word 0x100 = 0x80FF1234.
    run_req(1'b1, 3'b010, 32'h0000_0100, 32'h80FF_1234, lat, rd, er, en, ia, ibe, iwd);
    check("preload SW latency", lat, 2);

    run_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, lat, rd, er, en, ia, ibe, iwd);
    check("LB rdata", rd, 32'hFFFF_FF80);
    check("LB latency", lat, 3);
    run_req(1'b0, 3'b100, 32'h0000_0103, 32'h0, lat, rd, er, en, ia, ibe, iwd);
    check("LBU rdata", rd, 32'h0000_0080);
    check("LBU latency", lat, 3);

    run_req(1'b0, 3'b001, 32'h0000_0101, 32'h0, lat, rd, er, en, ia, ibe, iwd);
    check("LH misaligned rsp_err", er, TRAP ? 1 : 0);
    check("LH misaligned rdata", rd, TRAP ? 32'h0 : 32'h0000_1234);
    check("LH misaligned latency", lat, TRAP ? 1 : 3);
    check("LH misaligned mem_en seen", en, TRAP ? 0 : 1);

    run_req(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5, lat, rd, er, en, ia, ibe, iwd);
    check("SB mem_be", ibe, 4'b0100);
    check("SB lane data", (iwd >> 16) & 32'hFF, 32'hA5);
    check("SB rsp_rdata", rd, 32'h0);

    run_req(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, lat, rd, er, en, ia, ibe, iwd);
    check("SW mem_addr", ia, 16'h0041);
    check("SW mem_be", ibe, 4'b1111);
    check("SW mem_wdata", iwd, 32'hDEAD_BEEF);
    check("SW latency", lat, 2);

    run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, rd, er, en, ia, ibe, iwd);
    check("LW after SB", rd, 32'h80A5_1234);

    // Reset while a load sits in WAIT.
    @(negedge clk);
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0000_0100;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", bus.req_ready, 1);
    check("post-rst mem_en", bus.mem_en, 0);
    check("post-rst rsp_valid", bus.rsp_valid, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("dropped rsp_valid", bus.rsp_valid, 0);
    end

    // Back-to-back SW then LW with req_valid held.
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0000_0108; bus.req_wdata = 32'h1357_9BDF;
    @(posedge clk); #2;
    bus.req_we = 1'b0; bus.req_wdata = 32'h0;
    d1 = -1; d2 = -1; r2 = 1'bx; r3 = 1'bx; dropped = 1'b0; rd = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 2) r2 = bus.req_ready;
      if (n == 3) r3 = bus.req_ready;
      if (bus.rsp_valid) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) begin d2 = n; rd = bus.rsp_rdata; end
      end
      if (d2 > 0) break;
      if (bus.req_ready && d1 > 0 && !dropped) begin
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        dropped = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b SW done cycle", d1, 2);
    check("b2b ready during DONE", r2, 0);
    check("b2b ready after DONE", r3, 1);
    check("b2b LW done cycle", d2, 6);
    check("b2b LW rdata", rd, 32'h1357_9BDF);

    // Randomized traffic, including requests while busy and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      rst              = ($urandom_range(0, 63) == 0);
      bus.req_valid    = $urandom_range(0, 1) == 1;
      bus.req_we       = $urandom_range(0, 1) == 1;
      bus.req_funct3   = 3'($urandom_range(0, 7));
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the CPU's ALU result/RD2 path and a synchronous-read data memory. It takes one request at a time, generates byte enables and lane-shifted write data for stores, and for loads extracts and sign/zero-extends the addressed byte, halfword or word. It returns the result with a one-cycle `rsp_valid` pulse. The CPU holds its PC while `busy` is high.

## Interface
- `DATA_WIDTH`, 32: data path width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte address width from the ALU.
- `MEM_ADDR_WIDTH`, 16: word address width to memory; `mem_addr = addr[MEM_ADDR_WIDTH+1:2]`.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_WIDTH  byte address (ALU result).
- `req_wdata`  in  DATA_WIDTH  store data (RD2), right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores.
- `rsp_err`  out  1  misaligned access; qualified by `rsp_valid`.
- `busy`  out  1  state != IDLE.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_be`  out  4  byte enables.
- `mem_addr`  out  MEM_ADDR_WIDTH  word address.
- `mem_wdata`  out  DATA_WIDTH  lane-shifted store data.
- `mem_rdata`  in  DATA_WIDTH  read data, valid the cycle after a read strobe.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: `req_ready` = 1. On `req_valid`, latch addr, funct3, we and wdata, then go to ISSUE.
  - ISSUE: drive `mem_en` = 1, `mem_we` = latched we, and `mem_be`/`mem_addr`/`mem_wdata`. A store goes to DONE; a load goes to WAIT.
  - WAIT: capture extended `mem_rdata` into the response register, then go to DONE.
  - DONE: `rsp_valid` = 1 for one cycle, then go to IDLE.
- Byte enables use `off = addr[1:0]`:
  - Byte: `mem_be = 0001 << off`.
  - Half: `mem_be = 0011 << (off & 2)`.
  - Word: `mem_be = 1111`.
- Store data: `mem_wdata = wdata << (8 * lane)`; bits outside the enabled lanes are don't-care.
- Load extraction: select the lane, then sign-extend for B/H or zero-extend for BU/HU.
- Undefined funct3 values (011, 110, 111) are treated as W. Store funct3 bit 2 is ignored.
- `mem_en`, `mem_we` and `mem_be` are 0 in every state except ISSUE.
- `rsp_rdata` and `rsp_err` hold their values until the next DONE.

## Timing
- Request accepted at cycle N.
- Store: memory write at N+1, `rsp_valid` at N+2.
- Load: read strobe at N+1, `mem_rdata` sampled at N+2, `rsp_valid` at N+3.
- Back-to-back: the next request can be accepted in the cycle after DONE. `req_ready` is 0 during DONE.
- Reset (any state, including mid-access):
  - Next cycle: IDLE, `req_ready` = 1, all other outputs 0.
  - A pending response is dropped, with no `rsp_valid`.
  - A write already strobed in ISSUE is not undone.
- A `req_valid` asserted in the same cycle as `rst` is ignored.

## Configuration
- `LOAD_STORE_MISALIGN_TRAP_EN` defined:
  - Misalignment means H/HU with `addr[0] = 1`, or W with `addr[1:0] != 0`.
  - A misaligned request goes IDLE to DONE directly, with no `mem_en`.
  - Response: `rsp_err` = 1, `rsp_rdata` = 0, `rsp_valid` at N+1.
- Undefined: alignment bits below the access size are forced to 0 (H uses `off & 2`, W uses 0), and `rsp_err` is tied to 0.

## Structure
- `load_store_pkg`:
  - FSM state enum.
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - Size-decode function.
- Sub-module `load_store_align` (purely combinational): builds byte enables and write-data shifting from (funct3, off, wdata), and does read-lane extraction and extension from (funct3, off, rdata). The parent holds all state.

## Test plan
- SW 0xDEADBEEF at 0x0000_0104 → ISSUE cycle shows `mem_addr` = 0x0041, `mem_be` = 1111, `mem_wdata` = 0xDEADBEEF; `rsp_valid` at N+2.
- SB 0x0000_00A5 at 0x0000_0102 → `mem_be` = 0100, `mem_wdata[23:16]` = 0xA5; `rsp_rdata` = 0.
- LB and LBU at 0x0000_0103 with memory word 0x80FF_1234 → LB `rsp_rdata` = 0xFFFF_FF80, LBU `rsp_rdata` = 0x0000_0080; each at N+3.
- LH at 0x0000_0101:
  - With the macro: `rsp_err` = 1, no `mem_en`, `rsp_valid` at N+1.
  - Without: reads the lower halfword; for word 0x80FF_1234, `rsp_rdata` = 0x0000_1234.
- Assert `rst` during WAIT of a load → no `rsp_valid`; next cycle IDLE with `req_ready` = 1 and `mem_en` = 0.
- Back-to-back SW then LW to the same address with `req_valid` held → second accept one cycle after the first DONE; LW returns the stored value.
